// File: rtl/timer_set_ctrl.sv
// ---------------------------------------------------------------------------
// timer_set_ctrl
//   Front-panel controller for a clock: conditions the two raw buttons
//   (2-flop synchroniser + debouncer + press edge detect), generates the
//   once-per-second counter enable, and runs the RUN / SET_SEC / SET_MIN /
//   SET_HOUR mode machine with an idle timeout back to RUN.
//
// Ports
//   clk        in   system clock, all state on its rising edge
//   CLR_n      in   asynchronous clear, ACTIVE HIGH despite the name
//   btn_mode   in   raw mode button, active high, asynchronous
//   btn_inc    in   raw increment button, active high, asynchronous
//   one_HZ     out  one-cycle pulse per second, only while in RUN
//   isSetting  out  1 in any SET state
//   sel        out  field being set: 0 none, 1 sec, 2 min, 3 hour
//   inc_pulse  out  one-cycle increment strobe for the selected field
//   blink      out  display blink enable (first half of each second, SET only)
//
// Every output is a flop loaded from the next-state values, so the outputs
// carry no combinational path from the buttons and match the state in the
// cycle the state becomes visible.
// ---------------------------------------------------------------------------
module timer_set_ctrl #(
    parameter int CLK_HZ    = 1000,
    parameter int DEB_CYC   = 20,
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       CLR_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       one_HZ,
    output logic       isSetting,
    output logic [1:0] sel,
    output logic       inc_pulse,
    output logic       blink
);

    localparam int PW = $clog2(CLK_HZ);
    localparam int IW = $clog2(TIMEOUT_S + 1);
    localparam int DW = $clog2(DEB_CYC);

    localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(CLK_HZ / 2);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_S);
    localparam logic [IW-1:0] IDLE_ONE = IW'(1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYC - 1);
    localparam logic [DW-1:0] DEB_ONE  = DW'(1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_SEC  = 2'd1,
        ST_MIN  = 2'd2,
        ST_HOUR = 2'd3
    } state_t;

    // Button index 0 is mode, index 1 is inc.
    logic [1:0]    raw_s;
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    lvl_q, lvl_d, lvl_prev_q;
    logic [DW-1:0] deb_cnt_q [2];
    logic [DW-1:0] deb_cnt_d [2];
    logic [1:0]    press_s;
    logic          mode_ev_s, inc_ev_s;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          in_set_s, sec_strobe_s, timeout_s;

    logic          one_hz_q, one_hz_d;
    logic          set_q, set_d;
    logic [1:0]    sel_q, sel_d;
    logic          inc_q, inc_d;
    logic          blink_q, blink_d;

    assign raw_s     = {btn_inc, btn_mode};
    assign press_s   = lvl_q & ~lvl_prev_q;
    assign mode_ev_s = press_s[0];
    assign inc_ev_s  = press_s[1];

    // Two-flop synchronisers for both buttons.
    always_ff @(posedge clk or posedge CLR_n) begin
        if (CLR_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a new level after DEB_CYC consecutive differing cycles.
    always_comb begin
        lvl_d = lvl_q;
        for (int b = 0; b < 2; b++) begin
            deb_cnt_d[b] = deb_cnt_q[b];
            if (sync2_q[b] != lvl_q[b]) begin
                if (deb_cnt_q[b] == DEB_MAX) begin
                    lvl_d[b]     = sync2_q[b];
                    deb_cnt_d[b] = '0;
                end else begin
                    deb_cnt_d[b] = deb_cnt_q[b] + DEB_ONE;
                end
            end else begin
                deb_cnt_d[b] = '0;
            end
        end
    end

    // Debounce state and previous level for press edge detection.
    always_ff @(posedge clk or posedge CLR_n) begin
        if (CLR_n) begin
            lvl_q        <= 2'b00;
            lvl_prev_q   <= 2'b00;
            deb_cnt_q[0] <= '0;
            deb_cnt_q[1] <= '0;
        end else begin
            lvl_q        <= lvl_d;
            lvl_prev_q   <= lvl_q;
            deb_cnt_q[0] <= deb_cnt_d[0];
            deb_cnt_q[1] <= deb_cnt_d[1];
        end
    end

    // Mode machine, prescaler, idle timer and next output values.
    always_comb begin
        in_set_s     = (state_q != ST_RUN);
        sec_strobe_s = (presc_q == PRE_MAX);
        timeout_s    = in_set_s && (idle_q == IDLE_MAX);

        state_d = state_q;
        if (mode_ev_s) begin
            case (state_q)
                ST_RUN:  state_d = ST_SEC;
                ST_SEC:  state_d = ST_MIN;
                ST_MIN:  state_d = ST_HOUR;
                ST_HOUR: state_d = ST_RUN;
                default: state_d = ST_RUN;
            endcase
        end else if (timeout_s) begin
            state_d = ST_RUN;
        end else begin
            state_d = state_q;
        end

        // Re-phase the second on every return to RUN so the first one_HZ
        // arrives a full second later; SET states keep counting for blink.
        if (in_set_s && (state_d == ST_RUN)) begin
            presc_d = '0;
        end else if (sec_strobe_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PRE_ONE;
        end

        // Idle is held at 0 in RUN, which also clears it on entry to SET.
        if (mode_ev_s || inc_ev_s || !in_set_s) begin
            idle_d = '0;
        end else if (sec_strobe_s && (idle_q != IDLE_MAX)) begin
            idle_d = idle_q + IDLE_ONE;
        end else begin
            idle_d = idle_q;
        end

        // Mode wins over inc; an inc landing on the timeout cycle is dropped
        // because the machine is leaving SET in that same cycle.
        inc_d    = inc_ev_s && !mode_ev_s && in_set_s && !timeout_s;
        sel_d    = state_d;
        set_d    = (state_d != ST_RUN);
        one_hz_d = (state_d == ST_RUN) && (presc_d == PRE_MAX);
        blink_d  = (state_d != ST_RUN) && (presc_d < PRE_HALF);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge CLR_n) begin
        if (CLR_n) begin
            state_q  <= ST_RUN;
            presc_q  <= '0;
            idle_q   <= '0;
            one_hz_q <= 1'b0;
            set_q    <= 1'b0;
            sel_q    <= 2'd0;
            inc_q    <= 1'b0;
            blink_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            idle_q   <= idle_d;
            one_hz_q <= one_hz_d;
            set_q    <= set_d;
            sel_q    <= sel_d;
            inc_q    <= inc_d;
            blink_q  <= blink_d;
        end
    end

    assign one_HZ    = one_hz_q;
    assign isSetting = set_q;
    assign sel       = sel_q;
    assign inc_pulse = inc_q;
    assign blink     = blink_q;

endmodule
